// File: rtl/ac_fan_driver_if.sv
// Fan driver bus: speed request and tachometer in, PWM drive and status out.
// The tach line exists only when FAN_TACH_EN is defined.
interface ac_fan_driver_if;
  logic [2:0] fan_speed;
`ifdef FAN_TACH_EN
  logic       tach;
`endif
  logic       pwm_out;
  logic [7:0] duty;
  logic       fan_on;
  logic       at_speed;
  logic       fault;

`ifdef FAN_TACH_EN
  modport master (output fan_speed, output tach,
                  input pwm_out, input duty, input fan_on, input at_speed, input fault);
  modport slave  (input fan_speed, input tach,
                  output pwm_out, output duty, output fan_on, output at_speed, output fault);
`else
  modport master (output fan_speed,
                  input pwm_out, input duty, input fan_on, input at_speed, input fault);
  modport slave  (input fan_speed,
                  output pwm_out, output duty, output fan_on, output at_speed, output fault);
`endif
endinterface

// File: rtl/ac_fan_driver.sv
// AC fan driver: ramped 8-bit duty toward a speed-level target, glitch-free PWM.
// Optional stall detection on the tach input is enabled by defining FAN_TACH_EN.
module ac_fan_driver #(
  parameter int unsigned RAMP_DIV    = 16,
  parameter int unsigned STALL_LIMIT = 50000
) (
  input  logic           clk,
  input  logic           reset,
  ac_fan_driver_if.slave bus
);

  localparam int unsigned PRESC_W = 16;
  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned STALL_W = 16;

  if (RAMP_DIV < 1 || RAMP_DIV > 65535) begin : g_chk_ramp_div
    $error("RAMP_DIV must be in 1..65535");
  end
  if (STALL_LIMIT < 1 || STALL_LIMIT > 65535) begin : g_chk_stall_limit
    $error("STALL_LIMIT must be in 1..65535");
  end

  typedef enum logic [1:0] {S_OFF, S_RAMP, S_RUN, S_FAULT} state_e;

  state_e              r_state;
  logic [DUTY_W-1:0]   r_target;
  logic [PRESC_W-1:0]  r_presc;
  logic [DUTY_W-1:0]   r_duty;
  logic [DUTY_W-1:0]   r_duty_active;
  logic [DUTY_W-1:0]   r_pwm_cnt;
  logic                r_pwm_out;
  logic                r_fan_on;
  logic                r_at_speed;

  state_e              w_state_nxt;
  logic [DUTY_W-1:0]   w_target_map;
  logic [DUTY_W-1:0]   w_duty_nxt;
  logic                w_wrap;
  logic                w_stall_hit;
  logic                w_to_fault;

  always_comb begin
    w_target_map = DUTY_W'(255);
    case (bus.fan_speed)
      3'd0: w_target_map = DUTY_W'(0);
      3'd1: w_target_map = DUTY_W'(64);
      3'd2: w_target_map = DUTY_W'(128);
      3'd3: w_target_map = DUTY_W'(192);
      default: w_target_map = DUTY_W'(255);
    endcase
  end

  assign w_wrap = (r_presc == PRESC_W'(RAMP_DIV - 1));

`ifdef FAN_TACH_EN
  logic               r_tach_s1;
  logic               r_tach_s2;
  logic               r_tach_d;
  logic [STALL_W-1:0] r_stall;
  logic               r_fault;
  logic               w_tach_edge;

  assign w_tach_edge = r_tach_s2 & ~r_tach_d;
  assign w_stall_hit = (r_state == S_RUN) && !w_tach_edge &&
                       (r_stall == STALL_W'(STALL_LIMIT - 1));

  // Tach synchronizer, edge detect and stall counter (only live in RUN)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tach_s1 <= 1'b0;
      r_tach_s2 <= 1'b0;
      r_tach_d  <= 1'b0;
      r_stall   <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_tach_s1 <= bus.tach;
      r_tach_s2 <= r_tach_s1;
      r_tach_d  <= r_tach_s2;
      if (r_state != S_RUN || w_tach_edge) r_stall <= '0;
      else                                 r_stall <= r_stall + STALL_W'(1);
      r_fault   <= (w_state_nxt == S_FAULT);
    end
  end

  assign bus.fault = r_fault;
`else
  assign w_stall_hit = 1'b0;
  assign bus.fault   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OFF:   if (r_target != '0) w_state_nxt = S_RAMP;
      S_RAMP:  if (r_duty == r_target)
                 w_state_nxt = (r_target != '0) ? S_RUN : S_OFF;
      S_RUN:   if (w_stall_hit)              w_state_nxt = S_FAULT;
               else if (r_target != r_duty)  w_state_nxt = S_RAMP;
      S_FAULT: if (r_target == '0) w_state_nxt = S_OFF;
      default: w_state_nxt = S_OFF;
    endcase
  end

  assign w_to_fault = (w_state_nxt == S_FAULT);

  // Ramp one LSB per prescaler wrap; the compare-before-step keeps it inside 0..255
  always_comb begin
    w_duty_nxt = r_duty;
    if (w_to_fault) begin
      w_duty_nxt = '0;
    end else if (w_wrap) begin
      if (r_duty < r_target)      w_duty_nxt = r_duty + DUTY_W'(1);
      else if (r_duty > r_target) w_duty_nxt = r_duty - DUTY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_OFF;
      r_target      <= '0;
      r_presc       <= '0;
      r_duty        <= '0;
      r_duty_active <= '0;
      r_pwm_cnt     <= '0;
      r_pwm_out     <= 1'b0;
      r_fan_on      <= 1'b0;
      r_at_speed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_map;
      r_presc    <= w_wrap ? '0 : r_presc + PRESC_W'(1);
      r_duty     <= w_duty_nxt;
      r_pwm_cnt  <= r_pwm_cnt + DUTY_W'(1);
      r_fan_on   <= (w_duty_nxt != '0);
      r_at_speed <= (w_state_nxt == S_RUN);
      // Duty is only sampled at the period boundary so a period never changes width
      if (w_to_fault)                  r_duty_active <= '0;
      else if (r_pwm_cnt == 8'hFF)     r_duty_active <= r_duty;
      r_pwm_out  <= !w_to_fault && (r_pwm_cnt < r_duty_active);
    end
  end

  assign bus.pwm_out  = r_pwm_out;
  assign bus.duty     = r_duty;
  assign bus.fan_on   = r_fan_on;
  assign bus.at_speed = r_at_speed;

endmodule

// File: tb/tb_ac_fan_driver.sv
// Scoreboard bench for ac_fan_driver (RAMP_DIV=4, STALL_LIMIT=1000).
// Stall-fault scenario is included when FAN_TACH_EN is defined.
module tb_ac_fan_driver;

  logic clk;
  logic reset;
  ac_fan_driver_if bus();

  ac_fan_driver #(.RAMP_DIV(4), .STALL_LIMIT(1000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_DUTY, K_PWM, K_FAN_ON, K_AT_SPEED, K_FAULT, K_WIN} kind_e;
  typedef struct {
    kind_e kind;
    int    exp;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_busy = 1'b0;

  task automatic push(input kind_e k, input int v, input string n);
    exp_t e;
    e.kind = k; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  function automatic int sample(input kind_e k);
    case (k)
      K_DUTY:     return int'(bus.duty);
      K_PWM:      return int'(bus.pwm_out);
      K_FAN_ON:   return int'(bus.fan_on);
      K_AT_SPEED: return int'(bus.at_speed);
      K_FAULT:    return int'(bus.fault);
      default:    return -1;
    endcase
  endfunction

  // Monitor: scalar expectations at the next sample point; K_WIN counts pwm highs over 256 cycles
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(posedge clk); #1;
      while (q.size() > 0 && q[0].kind != K_WIN) begin
        e = q.pop_front();
        act = sample(e.kind);
        n_cmp++;
        if (act != e.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, act, e.exp, $time);
        end
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        mon_busy = 1'b1;
        act = int'(bus.pwm_out);
        repeat (255) begin
          @(posedge clk); #1;
          act += int'(bus.pwm_out);
        end
        n_cmp++;
        if (act != e.exp) begin
          n_bad++;
          $display("FAIL %s: pwm high %0d of 256, expected %0d (t=%0t)", e.name, act, e.exp, $time);
        end
        mon_busy = 1'b0;
      end
    end
  end

`ifdef FAN_TACH_EN
  bit tach_run = 1'b1;
  initial begin
    bus.tach = 1'b0;
    forever begin
      if (tach_run) begin
        bus.tach = 1'b1;
        repeat (5) @(negedge clk);
        bus.tach = 1'b0;
        repeat (95) @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
  end
`endif

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (q.size() == 0 && !mon_busy) return;
      @(negedge clk);
    end
    $display("FAIL drain: scoreboard still holds %0d entries", q.size());
    $fatal(1, "scoreboard did not drain");
  endtask

  task automatic do_reset(input logic [2:0] s);
    reset = 1'b0;
    bus.fan_speed = s;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_duty(input int v, input int budget, input string n);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(bus.duty) == v) return;
    end
    push(K_DUTY, v, n);
  endtask

  task automatic push_all_zero(input string n);
    push(K_DUTY,     0, {n, "_duty"});
    push(K_PWM,      0, {n, "_pwm"});
    push(K_FAN_ON,   0, {n, "_fan_on"});
    push(K_AT_SPEED, 0, {n, "_at_speed"});
    push(K_FAULT,    0, {n, "_fault"});
  endtask

  initial begin
    reset = 1'b1;
    bus.fan_speed = 3'd0;
    #2 reset = 1'b0;
    @(negedge clk);
    push_all_zero("reset");
    repeat (3) @(negedge clk);

    // Speed 2: duty = floor(k/4) after release edge k; latched at edges 256, 512, 768
    do_reset(3'd2);
    repeat (256) @(posedge clk);
    @(negedge clk);
    push(K_WIN, 63,  "win_ramp_63");
    push(K_WIN, 127, "win_ramp_127");
    push(K_WIN, 128, "win_run_128");
    drain();
    push(K_DUTY,     128, "spd2_duty");
    push(K_AT_SPEED, 1,   "spd2_at_speed");
    push(K_FAN_ON,   1,   "spd2_fan_on");
    push(K_FAULT,    0,   "spd2_fault");
    drain();

    // Speed 1 from RUN at 128: ramp down to 64 and settle in RUN
    bus.fan_speed = 3'd1;
    wait_duty(64, 600, "spd1_reach_64");
    repeat (3) @(negedge clk);
    push(K_DUTY,     64, "spd1_duty");
    push(K_AT_SPEED, 1,  "spd1_at_speed");
    drain();

    // Speed 4 up to 100, then off: ramp reverses and settles at 0
    do_reset(3'd4);
    wait_duty(100, 600, "rev_reach_100");
    bus.fan_speed = 3'd0;
    push(K_AT_SPEED, 0, "rev_ramping");
    wait_duty(0, 800, "rev_reach_0");
    repeat (3) @(negedge clk);
    push(K_DUTY,     0, "rev_duty");
    push(K_FAN_ON,   0, "rev_fan_on");
    push(K_AT_SPEED, 0, "rev_at_speed");
    push(K_PWM,      0, "rev_pwm");
    drain();

    // Speed 7 clamps to 255: duty 255 from edge 1020, latched at 1024
    do_reset(3'd7);
    repeat (768) @(posedge clk);
    @(negedge clk);
    push(K_WIN, 191, "win_ramp_191");
    push(K_WIN, 255, "win_full_a");
    push(K_WIN, 255, "win_full_b");
    drain();
    push(K_DUTY,     255, "spd7_duty");
    push(K_AT_SPEED, 1,   "spd7_at_speed");
    drain();

    // Reset mid-ramp at duty 50, then ramp restarts from 0
    do_reset(3'd4);
    wait_duty(50, 400, "rst_reach_50");
    reset = 1'b0;
    push_all_zero("rst_mid");
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    push(K_DUTY,   1, "restart_duty1");
    push(K_FAN_ON, 1, "restart_fan_on");
    repeat (4) @(posedge clk);
    @(negedge clk);
    push(K_DUTY, 2, "restart_duty2");
    drain();

`ifdef FAN_TACH_EN
    // Stall: RUN at 192 with tach pulsing, then tach stops
    begin
      bit seen;
      do_reset(3'd3);
      wait_duty(192, 1000, "tach_reach_192");
      repeat (20) @(negedge clk);
      push(K_AT_SPEED, 1, "tach_at_speed");
      repeat (1500) @(negedge clk);
      push(K_FAULT,    0, "tach_alive_fault");
      push(K_AT_SPEED, 1, "tach_alive_run");
      tach_run = 1'b0;
      repeat (850) @(negedge clk);
      push(K_FAULT, 0, "stall_early");
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk);
        if (bus.fault) seen = 1'b1;
      end
      push(K_FAULT, 1, "stall_fault");
      push(K_PWM,   0, "stall_pwm_low");
      push(K_DUTY,  0, "stall_duty");
      repeat (40) @(negedge clk);
      push(K_DUTY,     0, "fault_frozen_duty");
      push(K_FAULT,    1, "fault_held");
      push(K_AT_SPEED, 0, "fault_at_speed");
      bus.fan_speed = 3'd0;
      repeat (4) @(negedge clk);
      push(K_FAULT,  0, "fault_cleared");
      push(K_DUTY,   0, "fault_off_duty");
      push(K_FAN_ON, 0, "fault_off_fan_on");
      drain();
    end
`endif

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ac_fan_driver.md
AC_FAN_DRIVER -- requirements
Module: ac_fan_driver

Interface
REQ-001 Parameter RAMP_DIV, default 16: clock cycles per one-LSB duty step (legal range 1..65535).
REQ-002 Parameter STALL_LIMIT, default 50000: clock cycles without a tach edge in RUN before a fault is raised (16-bit, nonzero).
REQ-003 Port clk, input, 1 bit: the single system clock; all logic clocks on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port fan_speed, input, 3 bits: requested speed level from the AC control stage (0 = off, 4 = fastest).
REQ-006 Port tach, input, 1 bit: fan tachometer pulse, asynchronous; exists only when FAN_TACH_EN is defined.
REQ-007 Port pwm_out, output, 1 bit: registered PWM drive to the fan motor.
REQ-008 Port duty, output, 8 bits: current ramped duty value.
REQ-009 Port fan_on, output, 1 bit: high when duty is nonzero.
REQ-010 Port at_speed, output, 1 bit: high when the state is RUN.
REQ-011 Port fault, output, 1 bit: stall fault flag.

Function
REQ-012 fan_speed is registered into target every cycle, with 1 cycle of latency; mapping: 0->0, 1->64, 2->128, 3->192, 4..7->255 (values 5..7 clamp).
REQ-013 A prescaler counts 0..RAMP_DIV-1 and wraps; on each wrap, duty moves 1 LSB toward target, or holds if equal to target.
REQ-014 A change of target mid-ramp reverses or continues the ramp at the next prescaler wrap; there is no restart and no jump.
REQ-015 An 8-bit free-running counter pwm_cnt runs 0..255 and wraps.
REQ-016 duty_active loads from duty only when pwm_cnt==255, so there are no mid-period glitches.
REQ-017 pwm_out registers (pwm_cnt < duty_active):
- duty_active 0 -> pwm_out constant low.
- duty_active 255 -> pwm_out high 255 of every 256 cycles.
REQ-018 State machine states: OFF, RAMP, RUN, FAULT. Transitions are evaluated every cycle:
- OFF->RAMP when target!=0.
- RAMP->RUN when duty==target!=0.
- RAMP->OFF when duty==target==0.
- RUN->RAMP when target!=duty.
REQ-019 fan_on = (duty!=0); at_speed = (state==RUN). Both are registered alongside state.
REQ-020 Arithmetic: duty never wraps below 0 or above 255; the step logic saturates.

Reset
REQ-021 Asserting reset (low) asynchronously clears:
- pwm_out, duty, duty_active, target, fan_on, at_speed, fault, and all counters to 0;
- state to OFF.
REQ-022 Reset asserted mid-ramp or mid-period takes effect immediately, with no residual pwm pulse.
REQ-023 Release is synchronous in effect: the first active edge after deassertion samples fan_speed normally.

Configuration
REQ-024 Macro FAN_TACH_EN defined: tach port present; tach is passed through a 2-flop synchronizer and rising-edge detect.
REQ-025 With FAN_TACH_EN, the stall counter behaves as follows:
- In RUN it increments each cycle and clears on a tach edge.
- Outside RUN it is held at 0.
- Reaching STALL_LIMIT moves the state to FAULT.
REQ-026 With FAN_TACH_EN, FAULT behaviour:
- Entry: fault=1, duty and duty_active forced to 0 in the same cycle, so pwm_out is low on the next cycle.
- While in FAULT, the ramp is frozen.
- Exit: FAULT->OFF only when target==0, which clears fault.
REQ-027 Macro FAN_TACH_EN undefined: no tach port, no stall counter, FAULT state unreachable, fault tied to 0.

Verification (RAMP_DIV=4, STALL_LIMIT=1000 on bench)
REQ-028 Reset, fan_speed 0->2 -> duty steps 1 LSB every 4 cycles, reaches 128 about 512 cycles after target registers; at_speed=1 thereafter; pwm_out high 128 of 256.
REQ-029 fan_speed 4 until duty=100, then 0 -> duty reverses at next prescaler wrap, reaches 0 after about 400 cycles; state OFF, fan_on=0.
REQ-030 fan_speed=7 -> target 255; in RUN pwm_out high exactly 255 of each 256-cycle period.
REQ-031 Duty changes mid-period -> pwm_out width for that period matches the duty_active latched at pwm_cnt==255 (no glitch).
REQ-032 FAN_TACH_EN, RUN at 192, tach stopped -> fault=1 after 1000 cycles, pwm_out low next cycle; fan_speed=0 -> fault clears, OFF.
REQ-033 Reset pulsed low mid-ramp at duty=50 -> all outputs 0 immediately; ramp restarts from 0 after release.
